// File: rtl/conv_mac_unit_if.sv
// Request/response bundle between the convolution controller (master) and the MAC engine (slave).
// The controller drives startmult/clr/pix/wgt, and the engine returns completion, status and the accumulator.
interface conv_mac_unit_if #(
  parameter int n  = 8,
  parameter int aw = 20,
  parameter int cw = 4
);
  logic          startmult;
  logic          clr;
  logic [n-1:0]  pix;
  logic [n-1:0]  wgt;
  logic          donemult;
  logic          busy;
  logic [aw-1:0] acc_out;
  logic          result_valid;
  logic [cw-1:0] prod_cnt;

  modport master (
    output startmult, clr, pix, wgt,
    input  donemult, busy, acc_out, result_valid, prod_cnt
  );

  modport slave (
    input  startmult, clr, pix, wgt,
    output donemult, busy, acc_out, result_valid, prod_cnt
  );
endinterface

// File: rtl/conv_mac_unit.sv
// Shift-add MAC: one pixel*weight product per accepted startmult, with donemult n+2 cycles after acceptance.
// Requests that arrive while busy are dropped rather than queued, so the controller must wait for IDLE.
module conv_mac_unit #(
  parameter int n  = 8,
  parameter int p  = 3,
  parameter int aw = 20,
  parameter int cw = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  conv_mac_unit_if.slave bus
);

  localparam int BW = $clog2(n) + 1;
  localparam logic [cw-1:0] WIN = cw'(p * p);
  localparam logic [BW-1:0] LAST_BIT = BW'(n - 1);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_ACC, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [2*n-1:0]  r_mcand;
  logic [2*n-1:0]  r_prod;
  logic [n-1:0]    r_mplier;
  logic [BW-1:0]   r_bitcnt;
  logic [aw-1:0]   r_acc;
  logic [cw-1:0]   r_cnt;
  logic            w_clear;

  // clr behaves exactly like reset, including discarding a same-cycle request
  assign w_clear = i_rst | bus.clr;

  always_ff @(posedge i_clk) begin
    if (w_clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.startmult) w_next = S_MULT;
      S_MULT:  if (r_bitcnt == LAST_BIT) w_next = S_ACC;
      S_ACC:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_clear) begin
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_bitcnt <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.startmult) begin
            r_mcand  <= {{n{1'b0}}, bus.pix};
            r_mplier <= bus.wgt;
            r_prod   <= '0;
            r_bitcnt <= '0;
            // first product of a window starts the sum afresh
            if (r_cnt == '0) r_acc <= '0;
          end
        end
        S_MULT: begin
          if (r_mplier[0]) r_prod <= r_prod + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_bitcnt <= r_bitcnt + BW'(1);
        end
        S_ACC: begin
          r_acc <= r_acc + aw'(r_prod);
          r_cnt <= r_cnt + cw'(1);
        end
        S_DONE: begin
          if (r_cnt == WIN) r_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = (r_state != S_IDLE);
  assign bus.donemult     = (r_state == S_DONE);
  assign bus.result_valid = (r_state == S_DONE) && (r_cnt == WIN);
  assign bus.acc_out      = r_acc;
  assign bus.prod_cnt     = r_cnt;

endmodule

// File: tb/tb_conv_mac_unit.sv
// Randomised and directed checks of conv_mac_unit against an arithmetic window model.
module tb_conv_mac_unit;
  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   m_acc;
  int   m_cnt;

  conv_mac_unit_if #(.n(8), .aw(20), .cw(4)) bus ();

  conv_mac_unit #(.n(8), .p(3), .aw(20), .cw(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Window model: sum of unsigned products, restarting after every nine.
  task automatic model_op(input int a, input int b, output int e_acc, output int e_cnt, output logic e_rv);
    if (m_cnt == 0) m_acc = 0;
    m_acc = (m_acc + a * b) % (1 << 20);
    m_cnt = m_cnt + 1;
    e_acc = m_acc;
    e_cnt = m_cnt;
    e_rv  = (m_cnt == 9);
    if (m_cnt == 9) m_cnt = 0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_acc = 0;
    m_cnt = 0;
  endtask

  // Issues one request and observes it until the engine returns to idle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int poke_at,
                        output int lat, output int busy_n, output int ndone, output logic rv,
                        output logic [19:0] acc_d, output logic [3:0] cnt_d, output int tdone);
    bit fin;
    fin = 0; lat = 0; busy_n = 0; ndone = 0; rv = 0; acc_d = '0; cnt_d = '0; tdone = 0;
    @(negedge clk);
    bus.startmult = 1'b1;
    bus.pix = a;
    bus.wgt = b;
    for (int k = 1; k <= 40 && !fin; k++) begin
      @(posedge clk);
      #1;
      bus.startmult = (k == poke_at);
      if (k == poke_at) bus.pix = 8'd100;
      if (bus.busy) busy_n++;
      if (bus.donemult) begin
        ndone++;
        if (lat == 0) begin
          lat = k; rv = bus.result_valid; acc_d = bus.acc_out; cnt_d = bus.prod_cnt; tdone = cyc;
        end
      end
      if (lat != 0 && !bus.busy) fin = 1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; bus.startmult = 1'b1; bus.pix = 8'hff; bus.wgt = 8'hff;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.donemult, bus.busy, bus.result_valid, bus.acc_out, bus.prod_cnt} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got dm=%b busy=%b rv=%b acc=%0d cnt=%0d, want all 0",
               bus.donemult, bus.busy, bus.result_valid, bus.acc_out, bus.prod_cnt);
    end
    @(negedge clk);
    rst = 1'b0; bus.startmult = 1'b0;
    m_acc = 0; m_cnt = 0;
  endtask

  task automatic test_single();
    int lat, bn, nd, tdn, e_acc, e_cnt; logic rv, e_rv; logic [19:0] acc; logic [3:0] cnt;
    model_op(3, 4, e_acc, e_cnt, e_rv);
    run_op(8'd3, 8'd4, 0, lat, bn, nd, rv, acc, cnt, tdn);
    n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL single_latency: got %0d want 10", lat); end
    n_checks++; if (bn !== 10) begin n_fail++; $display("FAIL single_busy_cycles: got %0d want 10", bn); end
    n_checks++; if (acc !== 20'(e_acc)) begin n_fail++; $display("FAIL single_acc: got %0d want %0d", acc, e_acc); end
    n_checks++; if (cnt !== 4'(e_cnt) || rv !== e_rv || nd !== 1) begin
      n_fail++; $display("FAIL single_cnt_rv: got cnt=%0d rv=%b pulses=%0d want cnt=%0d rv=%b pulses=1", cnt, rv, nd, e_cnt, e_rv);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bn, nd, tdn, tprev, e_acc, e_cnt; logic rv, e_rv; logic [19:0] acc; logic [3:0] cnt;
    pulse_rst();
    tprev = 0;
    for (int i = 1; i <= 10; i++) begin
      logic [7:0] a;
      a = (i == 10) ? 8'd2 : 8'(i);
      model_op(a, (i == 10) ? 2 : 1, e_acc, e_cnt, e_rv);
      run_op(a, (i == 10) ? 8'd2 : 8'd1, 0, lat, bn, nd, rv, acc, cnt, tdn);
      n_checks++;
      if (acc !== 20'(e_acc) || rv !== e_rv || cnt !== 4'(e_cnt)) begin
        n_fail++;
        $display("FAIL b2b_op%0d: got acc=%0d rv=%b cnt=%0d want acc=%0d rv=%b cnt=%0d", i, acc, rv, cnt, e_acc, e_rv, e_cnt);
      end
      if (i > 1) begin
        n_checks++;
        if (tdn - tprev !== 11) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d want 11", i, tdn - tprev); end
      end
      if (i == 9) begin
        n_checks++;
        if (bus.prod_cnt !== 4'd0) begin n_fail++; $display("FAIL b2b_cnt_wrap: got %0d want 0", bus.prod_cnt); end
      end
      tprev = tdn;
    end
  endtask

  task automatic test_max();
    int lat, bn, nd, tdn, e_acc, e_cnt; logic rv, e_rv; logic [19:0] acc; logic [3:0] cnt;
    pulse_rst();
    for (int i = 1; i <= 9; i++) begin
      model_op(255, 255, e_acc, e_cnt, e_rv);
      run_op(8'd255, 8'd255, 0, lat, bn, nd, rv, acc, cnt, tdn);
    end
    n_checks++;
    if (acc !== 20'd585225 || rv !== 1'b1 || e_acc != 585225) begin
      n_fail++; $display("FAIL max_window: got acc=%0d rv=%b want acc=585225 rv=1", acc, rv);
    end
  endtask

  task automatic test_busy_ignore();
    int lat, bn, nd, tdn, e_acc, e_cnt; logic rv, e_rv; logic [19:0] acc; logic [3:0] cnt;
    model_op(7, 9, e_acc, e_cnt, e_rv);
    run_op(8'd7, 8'd9, 3, lat, bn, nd, rv, acc, cnt, tdn);
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.donemult || bus.busy) nd++;
    end
    n_checks++; if (acc !== 20'(e_acc)) begin n_fail++; $display("FAIL ignore_acc: got %0d want %0d", acc, e_acc); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL ignore_pulses: got %0d want 1", nd); end
  endtask

  task automatic test_rst_mid();
    int lat, bn, nd, tdn, e_acc, e_cnt; logic rv, e_rv; logic [19:0] acc; logic [3:0] cnt;
    pulse_rst();
    for (int i = 0; i < 2; i++) begin
      model_op(6, 7, e_acc, e_cnt, e_rv);
      run_op(8'd6, 8'd7, 0, lat, bn, nd, rv, acc, cnt, tdn);
    end
    @(negedge clk);
    bus.startmult = 1'b1; bus.pix = 8'd11; bus.wgt = 8'd13;
    @(posedge clk); #1;
    bus.startmult = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.donemult, bus.busy, bus.result_valid, bus.acc_out, bus.prod_cnt} !== 27'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got dm=%b busy=%b rv=%b acc=%0d cnt=%0d, want all 0",
               bus.donemult, bus.busy, bus.result_valid, bus.acc_out, bus.prod_cnt);
    end
    rst = 1'b0;
    m_acc = 0; m_cnt = 0;
    model_op(5, 5, e_acc, e_cnt, e_rv);
    run_op(8'd5, 8'd5, 0, lat, bn, nd, rv, acc, cnt, tdn);
    n_checks++;
    if (acc !== 20'(e_acc) || cnt !== 4'(e_cnt)) begin
      n_fail++; $display("FAIL rst_mid_fresh: got acc=%0d cnt=%0d want acc=%0d cnt=%0d", acc, cnt, e_acc, e_cnt);
    end
  endtask

  task automatic test_clr();
    int lat, bn, nd, tdn, e_acc, e_cnt; logic rv, e_rv; logic [19:0] acc; logic [3:0] cnt;
    pulse_rst();
    for (int i = 0; i < 3; i++) begin
      model_op(10 + i, 3, e_acc, e_cnt, e_rv);
      run_op(8'(10 + i), 8'd3, 0, lat, bn, nd, rv, acc, cnt, tdn);
    end
    @(negedge clk);
    bus.clr = 1'b1; bus.startmult = 1'b1; bus.pix = 8'd50; bus.wgt = 8'd50;
    @(posedge clk); #1;
    bus.clr = 1'b0; bus.startmult = 1'b0;
    m_acc = 0; m_cnt = 0;
    n_checks++;
    if (bus.acc_out !== 20'd0 || bus.prod_cnt !== 4'd0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL clr_state: got acc=%0d cnt=%0d busy=%b want 0 0 0", bus.acc_out, bus.prod_cnt, bus.busy);
    end
    nd = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.donemult) nd++;
    end
    n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL clr_no_done: got %0d pulses want 0", nd); end
  endtask

  task automatic test_random();
    int lat, bn, nd, tdn, e_acc, e_cnt, a, b; logic rv, e_rv; logic [19:0] acc; logic [3:0] cnt;
    pulse_rst();
    for (int i = 0; i < 20; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      model_op(a, b, e_acc, e_cnt, e_rv);
      run_op(8'(a), 8'(b), 0, lat, bn, nd, rv, acc, cnt, tdn);
      n_checks++;
      if (acc !== 20'(e_acc) || rv !== e_rv || cnt !== 4'(e_cnt) || lat !== 10) begin
        n_fail++;
        $display("FAIL random_op%0d %0d*%0d: got acc=%0d rv=%b cnt=%0d lat=%0d want acc=%0d rv=%b cnt=%0d lat=10",
                 i, a, b, acc, rv, cnt, lat, e_acc, e_rv, e_cnt);
      end
    end
  endtask

  initial begin
    cyc = 0; n_checks = 0; n_fail = 0; m_acc = 0; m_cnt = 0;
    rst = 1'b1;
    bus.startmult = 1'b0; bus.clr = 1'b0; bus.pix = '0; bus.wgt = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_max();
    test_busy_ignore();
    test_rst_mid();
    test_clr();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
